// File: rtl/ospfb_acc_pkg.sv
// Shared types and constants for the OSPFB power accumulator.
package ospfb_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ACCUM = 2'd2,
    LAST  = 2'd3
  } acc_state_t;

  localparam int LAT      = 5;
  localparam int CX_WIDTH = 16;

  // Native 16-bit complex sample layout on the FFT stream: im in the upper half.
  typedef struct packed {
    logic signed [CX_WIDTH-1:0] im;
    logic signed [CX_WIDTH-1:0] re;
  } cx_t;

endpackage

// File: rtl/cx_power.sv
// Three-stage registered complex power: re^2 + im^2, full precision, unsigned.
module cx_power #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic signed [WIDTH-1:0] re,
  input  logic signed [WIDTH-1:0] im,
  output logic [2*WIDTH:0]        power
);

  logic signed [WIDTH-1:0]   re_q;
  logic signed [WIDTH-1:0]   im_q;
  logic signed [2*WIDTH-1:0] re_sq;
  logic signed [2*WIDTH-1:0] im_sq;

  // Squares are never negative, so the signed products reinterpret safely as unsigned.
  always_ff @(posedge clk) begin
    re_q  <= re;
    im_q  <= im;
    re_sq <= (2*WIDTH)'(re_q) * (2*WIDTH)'(re_q);
    im_sq <= (2*WIDTH)'(im_q) * (2*WIDTH)'(im_q);
    power <= (2*WIDTH+1)'($unsigned(re_sq)) + (2*WIDTH+1)'($unsigned(im_sq));
  end

endmodule

// File: rtl/ospfb_power_acc.sv
// Per-bin power integrator behind the OSPFB; dumps one integrated spectrum per period.
//   state | meaning
//   IDLE  | en low, input ignored
//   FIRST | first spectrum: memory <= power
//   ACCUM | middle spectra: memory <= memory + power
//   LAST  | final spectrum: output memory + power, no write
module ospfb_power_acc
  import ospfb_acc_pkg::*;
#(
  parameter int    WIDTH       = 16,
  parameter int    FFT_LEN     = 2048,
  parameter int    ACC_WID     = 48,
  parameter int    ACC_LEN_WID = 16,
  parameter string MEM_TYPE    = "auto"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [ACC_LEN_WID-1:0]     acc_len,
  input  logic [2*WIDTH-1:0]         s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [ACC_WID-1:0]         m_axis_tdata,
  output logic [$clog2(FFT_LEN)-1:0] m_axis_tuser,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic                       event_tlast_unexpected,
  output logic                       event_tlast_missing,
  output logic                       event_overrun,
  output logic                       event_saturate,
  output logic [31:0]                dump_count
);

  localparam int               BIN_W   = $clog2(FFT_LEN);
  localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(FFT_LEN - 1);

  acc_state_t             state, state_d;
  logic [BIN_W-1:0]       bin_cnt, bin_d;
  logic [ACC_LEN_WID-1:0] spec_cnt, spec_d;
  logic [ACC_LEN_WID-1:0] acc_len_q, acc_len_eff;
  logic                   load_len, dump_inc;
  logic                   accept, eos, tlast_unexp, tlast_miss, single;

  assign s_axis_tready = 1'b1;
  assign acc_len_eff   = (acc_len == '0) ? ACC_LEN_WID'(1) : acc_len;
  assign accept        = s_axis_tvalid && (state != IDLE);
  assign eos           = accept && (bin_cnt == BIN_MAX);
  assign tlast_unexp   = accept && s_axis_tlast && (bin_cnt != BIN_MAX);
  assign tlast_miss    = eos && !s_axis_tlast;
  assign single        = (acc_len_q == ACC_LEN_WID'(1));

  always_comb begin
    state_d  = state;
    bin_d    = bin_cnt;
    spec_d   = spec_cnt;
    load_len = 1'b0;
    dump_inc = 1'b0;
    if (accept) bin_d = (bin_cnt == BIN_MAX) ? '0 : bin_cnt + 1'b1;
    if (!en) begin
      state_d = IDLE;
      bin_d   = '0;
      spec_d  = '0;
    end else if (state == IDLE) begin
      if (!s_axis_tvalid) begin
        state_d  = FIRST;
        load_len = 1'b1;
      end
    end else if (tlast_unexp) begin
      state_d  = FIRST;
      bin_d    = '0;
      spec_d   = '0;
      load_len = 1'b1;
    end else if (eos) begin
      spec_d = spec_cnt + 1'b1;
      case (state)
        FIRST: begin
          if (single) begin
            spec_d   = '0;
            load_len = 1'b1;
            dump_inc = 1'b1;
          end else if (acc_len_q == ACC_LEN_WID'(2)) begin
            state_d = LAST;
          end else begin
            state_d = ACCUM;
          end
        end
        ACCUM: if (spec_cnt == acc_len_q - ACC_LEN_WID'(2)) state_d = LAST;
        LAST: begin
          state_d  = FIRST;
          spec_d   = '0;
          load_len = 1'b1;
          dump_inc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bin_cnt    <= '0;
      spec_cnt   <= '0;
      acc_len_q  <= ACC_LEN_WID'(1);
      dump_count <= '0;
    end else begin
      state    <= state_d;
      bin_cnt  <= bin_d;
      spec_cnt <= spec_d;
      if (load_len) acc_len_q <= acc_len_eff;
      if (dump_inc) dump_count <= dump_count + 32'd1;
    end
  end

  logic [2*WIDTH:0]   power;
  logic [ACC_WID-1:0] rd_data;
  logic [ACC_WID:0]   sum_full;

  logic               s1_valid, s2_valid, s3_valid, s4_valid;
  logic               s1_first, s2_first, s3_first;
  logic               s1_last, s2_last, s3_last, s4_last;
  logic [BIN_W-1:0]   s1_bin, s2_bin, s3_bin, s4_bin;
  logic [ACC_WID-1:0] s3_mem, s4_sum;
  logic               s4_sat;
  logic               mem_we;

  cx_power #(.WIDTH(WIDTH)) u_power (
    .clk   (clk),
    .re    (s_axis_tdata[WIDTH-1:0]),
    .im    (s_axis_tdata[2*WIDTH-1:WIDTH]),
    .power (power)
  );

  assign sum_full = s3_first ? (ACC_WID+1)'(power)
                             : {1'b0, s3_mem} + (ACC_WID+1)'(power);
  assign mem_we   = s4_valid && !s4_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0; s4_valid <= 1'b0;
      s1_first <= 1'b0; s2_first <= 1'b0; s3_first <= 1'b0;
      s1_last  <= 1'b0; s2_last  <= 1'b0; s3_last  <= 1'b0; s4_last  <= 1'b0;
      s1_bin   <= '0;   s2_bin   <= '0;   s3_bin   <= '0;   s4_bin   <= '0;
      s3_mem   <= '0;
      s4_sum   <= '0;
      s4_sat   <= 1'b0;
      m_axis_tvalid          <= 1'b0;
      m_axis_tdata           <= '0;
      m_axis_tuser           <= '0;
      m_axis_tlast           <= 1'b0;
      event_tlast_unexpected <= 1'b0;
      event_tlast_missing    <= 1'b0;
      event_overrun          <= 1'b0;
      event_saturate         <= 1'b0;
    end else begin
      // A beat that triggers a framing error belongs to a discarded integration.
      s1_valid <= accept;
      s1_bin   <= bin_cnt;
      s1_first <= (state == FIRST);
      s1_last  <= ((state == LAST) || ((state == FIRST) && single)) && !tlast_unexp;
      s2_valid <= s1_valid; s2_bin <= s1_bin; s2_first <= s1_first; s2_last <= s1_last;
      s3_valid <= s2_valid; s3_bin <= s2_bin; s3_first <= s2_first; s3_last <= s2_last;
      s3_mem   <= rd_data;
      s4_valid <= s3_valid;
      s4_bin   <= s3_bin;
      s4_last  <= s3_last;
      s4_sat   <= s3_valid && sum_full[ACC_WID];
      s4_sum   <= sum_full[ACC_WID] ? '1 : sum_full[ACC_WID-1:0];
      m_axis_tvalid          <= s4_valid && s4_last;
      m_axis_tdata           <= s4_sum;
      m_axis_tuser           <= s4_bin;
      m_axis_tlast           <= (s4_bin == BIN_MAX);
      event_saturate         <= s4_sat;
      event_overrun          <= m_axis_tvalid && !m_axis_tready;
      event_tlast_unexpected <= tlast_unexp;
      event_tlast_missing    <= tlast_miss;
    end
  end

  // Read at s1, data lands in s2 and is staged to s3; write-back from s4.
  generate
    if (MEM_TYPE == "distributed") begin : g_lutram
      (* ram_style = "distributed" *) logic [ACC_WID-1:0] mem [FFT_LEN];
      always_ff @(posedge clk) begin
        if (mem_we) mem[s4_bin] <= s4_sum;
        rd_data <= mem[s1_bin];
      end
    end else begin : g_bram
      (* ram_style = "block" *) logic [ACC_WID-1:0] mem [FFT_LEN];
      always_ff @(posedge clk) begin
        if (mem_we) mem[s4_bin] <= s4_sum;
        rd_data <= mem[s1_bin];
      end
    end
  endgenerate

endmodule

// File: tb/tb_ospfb_power_acc.sv
// Directed bench for ospfb_power_acc with FFT_LEN=8, ACC_WID=33.
module tb_ospfb_power_acc;
  import ospfb_acc_pkg::*;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 33;
  localparam int LW = 16;
  localparam logic [63:0] SAT_VAL = 64'h1_FFFF_FFFF;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   en = 1'b0;
  logic [LW-1:0]          acc_len = '0;
  logic [2*W-1:0]         s_axis_tdata = '0;
  logic                   s_axis_tvalid = 1'b0;
  logic                   s_axis_tlast = 1'b0;
  logic                   s_axis_tready;
  logic [AW-1:0]          m_axis_tdata;
  logic [$clog2(N)-1:0]   m_axis_tuser;
  logic                   m_axis_tvalid;
  logic                   m_axis_tlast;
  logic                   m_axis_tready = 1'b1;
  logic                   event_tlast_unexpected;
  logic                   event_tlast_missing;
  logic                   event_overrun;
  logic                   event_saturate;
  logic [31:0]            dump_count;

  ospfb_power_acc #(
    .WIDTH(W), .FFT_LEN(N), .ACC_WID(AW), .ACC_LEN_WID(LW), .MEM_TYPE("auto")
  ) dut (
    .clk(clk), .rst(rst), .en(en), .acc_len(acc_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .event_tlast_unexpected(event_tlast_unexpected),
    .event_tlast_missing(event_tlast_missing),
    .event_overrun(event_overrun), .event_saturate(event_saturate),
    .dump_count(dump_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output/event monitor, sampled on the falling edge.
  logic [AW-1:0] out_data [256];
  int            out_bin  [256];
  logic          out_last [256];
  int            out_cyc  [256];
  int n_out = 0, n_sat = 0, n_over = 0, n_unexp = 0, n_miss = 0;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready && n_out < 256) begin
      out_data[n_out] = m_axis_tdata;
      out_bin[n_out]  = int'(m_axis_tuser);
      out_last[n_out] = m_axis_tlast;
      out_cyc[n_out]  = cyc;
      n_out++;
    end
    if (event_saturate)         n_sat++;
    if (event_overrun)          n_over++;
    if (event_tlast_unexpected) n_unexp++;
    if (event_tlast_missing)    n_miss++;
  end

  int n_asserts = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] pack(input int re, input int im);
    cx_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int re, input int im, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pack(re, im);
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic spec_const(input int re, input int im, input logic with_last);
    for (int b = 0; b < N; b++) beat(re, im, with_last && (b == N - 1));
  endtask

  task automatic spec_ramp(input int im);
    for (int b = 0; b < N; b++) beat(b, im, b == N - 1);
  endtask

  task automatic start(input int len);
    en = 1'b0;
    tick();
    acc_len = LW'(len);
    en = 1'b1;
    tick();
  endtask

  int base, bin0_cyc, sat0, ov0, ux0, ms0;
  int exp_bins [6] = '{0, 1, 4, 5, 6, 7};

  initial begin
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_dump", dump_count, 0);
    chk("rst_events", {event_tlast_unexpected, event_tlast_missing, event_overrun, event_saturate}, 0);
    chk("tready_tied", s_axis_tready, 1);
    rst = 1'b0;
    tick();

    // acc_len=4, constant 3+4j: every bin integrates to 4*25
    base = n_out;
    start(4);
    repeat (3) spec_const(3, 4, 1'b1);
    bin0_cyc = cyc;
    spec_const(3, 4, 1'b1);
    repeat (10) tick();
    chk("t1_count", n_out - base, 8);
    for (int i = 0; i < N; i++) begin
      chk("t1_data", out_data[base+i], 100);
      chk("t1_bin", out_bin[base+i], i);
      chk("t1_last", out_last[base+i], i == N - 1);
    end
    chk("t1_latency", out_cyc[base] - bin0_cyc, LAT);
    chk("t1_dump", dump_count, 1);
    chk("t1_no_events", n_sat + n_over + n_unexp + n_miss, 0);

    // acc_len=1: each spectrum is dumped directly as k^2
    base = n_out;
    start(1);
    spec_ramp(0);
    spec_ramp(0);
    repeat (10) tick();
    chk("t2_count", n_out - base, 16);
    for (int i = 0; i < 2 * N; i++) begin
      chk("t2_data", out_data[base+i], (i % N) * (i % N));
      chk("t2_bin", out_bin[base+i], i % N);
    end
    chk("t2_dump", dump_count, 3);

    // Full-scale negative input: 4 * 2^31 = 2^33 clips to 2^33-1
    base = n_out;
    sat0 = n_sat;
    start(4);
    repeat (4) spec_const(-32768, -32768, 1'b1);
    repeat (10) tick();
    chk("t3_count", n_out - base, 8);
    for (int i = 0; i < N; i++) chk("t3_data", out_data[base+i], SAT_VAL);
    chk("t3_sat_pulses", n_sat - sat0, 8);
    chk("t3_dump", dump_count, 4);

    // Early tlast at bin 3, then two clean spectra: (1+4) + (k^2+1)
    base = n_out;
    ux0 = n_unexp;
    start(2);
    for (int b = 0; b < 4; b++) beat(7, 7, b == 3);
    spec_const(1, 2, 1'b1);
    spec_ramp(1);
    repeat (10) tick();
    chk("t4_unexp_pulses", n_unexp - ux0, 1);
    chk("t4_count", n_out - base, 8);
    for (int i = 0; i < N; i++) begin
      chk("t4_data", out_data[base+i], i * i + 6);
      chk("t4_bin", out_bin[base+i], i);
    end
    chk("t4_dump", dump_count, 5);

    // Downstream not ready for bins 2 and 3 of a dump of 2 * 4
    base = n_out;
    ov0 = n_over;
    spec_const(2, 0, 1'b1);
    for (int t = 0; t < 16; t++) begin
      if (t < N) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pack(2, 0);
        s_axis_tlast  = (t == N - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      m_axis_tready = !(t == 7 || t == 8);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) tick();
    chk("t5_overrun_pulses", n_over - ov0, 2);
    chk("t5_count", n_out - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t5_data", out_data[base+i], 8);
      chk("t5_bin", out_bin[base+i], exp_bins[i]);
    end
    chk("t5_dump", dump_count, 6);

    // en dropped after 2 of 4 spectra, resumed with acc_len=2
    base = n_out;
    start(4);
    spec_const(1, 0, 1'b1);
    spec_const(1, 0, 1'b1);
    en = 1'b0;
    repeat (10) tick();
    chk("t6_no_partial", n_out - base, 0);
    acc_len = LW'(2);
    en = 1'b1;
    tick();
    spec_const(0, 3, 1'b1);
    spec_const(0, 3, 1'b1);
    repeat (10) tick();
    chk("t6_count", n_out - base, 8);
    for (int i = 0; i < N; i++) chk("t6_data", out_data[base+i], 18);
    chk("t6_dump", dump_count, 7);

    // Missing tlast on bin 7: flagged, processing continues
    base = n_out;
    ms0 = n_miss;
    spec_const(1, 0, 1'b0);
    spec_const(1, 0, 1'b1);
    repeat (10) tick();
    chk("t7_miss_pulses", n_miss - ms0, 1);
    chk("t7_count", n_out - base, 8);
    chk("t7_data", out_data[base+3], 2);
    chk("t7_dump", dump_count, 8);

    // Reset in the middle of a dump spectrum kills beats in flight
    base = n_out;
    spec_const(1, 0, 1'b1);
    beat(1, 0, 1'b0);
    beat(1, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("t8_no_output", n_out - base, 0);
    chk("t8_dump", dump_count, 0);
    chk("t8_tvalid", m_axis_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
